inst_fetch: RTL
===============

# inst_fetch

Instruction fetch and decode-register stage for the 3-bit-opcode accumulator core. It owns the program counter, reads the combinational instruction ROM and registers one instruction per cycle, presenting opcode and operand to the ALU/register-file stage downstream. It resolves the BZR and BZA branches against the ALU zero flag and stops the program at the halt opcode.

## Interface
- PC_W, 8, program-counter width; the instruction ROM depth is 2^PC_W.
- INST_W, 9, instruction width; opcode is [8:6] and operand is [5:0].
- CLK  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- start  in  1  one-cycle pulse; (re)starts execution at start_addr.
- start_addr  in  PC_W  first instruction address, sampled when start=1.
- instr_in  in  INST_W  ROM data; combinationally equal to rom[pc_out].
- z_flag  in  1  ALU zero flag for the instruction currently in the decode register.
- stall  in  1  downstream not ready; freezes the stage.
- pc_out  out  PC_W  ROM address (current PC).
- op  out  3  decoded opcode: LDR 000, CLR 001, ACC 010, ACI 011, BZR 100, BZA 101, STR 110, HALT 111.
- operand  out  6  instr[5:0] of the decode register.
- dec_pc  out  PC_W  address of the instruction held in the decode register.
- inst_valid  out  1  op/operand/dec_pc hold a real instruction this cycle.
- done  out  1  program halted.

## Operation
- State machine states: IDLE, RUN, HALT.
- Reset: state goes to IDLE. pc_out=0, op=000, operand=0, dec_pc=0, inst_valid=0, done=0.
- Priority, highest first: reset, start, stall, halt/branch, sequential fetch.
- start (any state): next state RUN, pc_out=start_addr, inst_valid=0, done=0. In RUN this flushes the instruction in flight.
- IDLE: all registers hold; inst_valid=0.
- RUN, stall=1: pc_out, the decode register, inst_valid and state all hold. z_flag is ignored.
- RUN, stall=0 (normal fetch): the decode register loads instr_in, dec_pc loads pc_out, inst_valid goes to 1, pc_out loads pc_out+1.
- Taken branch: the decode register is valid, op is BZR or BZA, and z_flag=1. Then pc_out loads the target and inst_valid goes to 0, squashing the instruction fetched this cycle.
  - BZR target: dec_pc + sign-extended operand.
  - BZA target: zero-extended operand.
- Not-taken branch (z_flag=0): normal fetch.
- op=111 in a valid decode register: next state HALT, done=1, inst_valid=0, pc_out holds (no increment).
- HALT: everything holds until start or reset.
- Arithmetic: pc_out+1 and the BZR target wrap modulo 2^PC_W. BZR offset range is -32..+31.
- z_flag is only examined while a valid BZR/BZA sits in decode and stall=0.

## Timing
- Fetch latency: address driven in cycle t; instruction appears on op/operand with inst_valid=1 in t+1.
- After start in cycle t:
  - t+1: pc_out=start_addr, inst_valid=0.
  - t+2: first valid instruction; pc_out=start_addr+1.
- Taken-branch penalty is one bubble. Branch is in decode at t. At t+1, pc_out=target and inst_valid=0. At t+2, the decode register holds rom[target] with inst_valid=1.
- Halt: HALT is in decode at t; done=1 from t+1.
- A stall in any cycle extends that cycle exactly, with no lost or duplicated instruction.
- Reset mid-run: outputs take their reset values at the next edge regardless of stall, start or branch.

## Test plan
- Reset, then start with start_addr=0x10 on a straight-line ROM (LDR, ACC, STR, HALT) -> op sequence 000, 010, 110 with dec_pc 0x10, 0x11, 0x12 on consecutive cycles; done=1 one cycle after HALT is decoded; pc_out frozen at 0x14.
- BZR at 0x02 with operand 6'b111100 (-4) and z_flag=1 -> one bubble (inst_valid=0), then dec_pc=0xFE (wrap); same case with z_flag=0 -> dec_pc=0x03 next, no bubble.
- BZA with operand 0x2A and z_flag=1 -> pc_out=0x2A one cycle later; next valid dec_pc=0x2A.
- stall held 3 cycles while a taken BZR is in decode, with z_flag toggling during the stall -> no state change during the stall; branch resolves on the first unstalled cycle using the z_flag of that cycle.
- HALT, wait 5 cycles, then start with start_addr=0x40 -> done clears next cycle and execution resumes at 0x40; start asserted mid-run -> the in-flight instruction is squashed and there is no inst_valid for the old PC.
- reset asserted mid-run coincident with start and stall -> all outputs at their reset values next cycle; state IDLE (inst_valid stays 0 without a new start).

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch and decode-register stage for the 3-bit-opcode accumulator core.
// Owns the program counter, registers one ROM word per cycle into the decode
// register, resolves BZR/BZA against the ALU zero flag and stops on HALT.
module inst_fetch #(
    parameter int PC_W   = 8,
    parameter int INST_W = 9
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic [INST_W-1:0] instr_in,
    input  logic              z_flag,
    input  logic              stall,
    output logic [PC_W-1:0]   pc_out,
    output logic [2:0]        op,
    output logic [5:0]        operand,
    output logic [PC_W-1:0]   dec_pc,
    output logic              inst_valid,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [2:0] OP_BZR  = 3'b100;
    localparam logic [2:0] OP_BZA  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic [1:0]      state;
    logic [PC_W-1:0] pcReg;
    logic [2:0]      opReg;
    logic [5:0]      operandReg;
    logic [PC_W-1:0] decPcReg;
    logic            validReg;
    logic            doneReg;

    logic            isHalt;
    logic            branchTaken;
    logic [PC_W-1:0] branchTarget;

    // Decode-stage resolution: halt detection, branch decision and branch target
    always_comb begin
        isHalt      = validReg && (opReg == OP_HALT);
        branchTaken = validReg && z_flag && ((opReg == OP_BZR) || (opReg == OP_BZA));
        if (opReg == OP_BZR) begin
            branchTarget = decPcReg + {{(PC_W-6){operandReg[5]}}, operandReg};
        end else begin
            branchTarget = {{(PC_W-6){1'b0}}, operandReg};
        end
    end

    // Program counter, decode register and run state, with reset > start > stall > halt/branch > fetch
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            pcReg      <= '0;
            opReg      <= '0;
            operandReg <= '0;
            decPcReg   <= '0;
            validReg   <= 1'b0;
            doneReg    <= 1'b0;
        end else if (start) begin
            state    <= RUN;
            pcReg    <= start_addr;
            validReg <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (isHalt) begin
                            state    <= HALT;
                            doneReg  <= 1'b1;
                            validReg <= 1'b0;
                        end else if (branchTaken) begin
                            pcReg    <= branchTarget;
                            validReg <= 1'b0;
                        end else begin
                            opReg      <= instr_in[8:6];
                            operandReg <= instr_in[5:0];
                            decPcReg   <= pcReg;
                            validReg   <= 1'b1;
                            pcReg      <= pcReg + 1'b1;
                        end
                    end
                end
                default: begin
                    validReg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out     = pcReg;
    assign op         = opReg;
    assign operand    = operandReg;
    assign dec_pc     = decPcReg;
    assign inst_valid = validReg;
    assign done       = doneReg;

endmodule
